// File: rtl/ooo_reg_scoreboard.sv
// Register ownership scoreboard: one busy bit and owner tag per integer register.
// Set at dispatch, cleared by a tag-matching writeback, bulk-cleared on flush.
module ooo_reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int TAG_W    = 4,
  parameter int NUM_WB   = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    flush,
  input  logic                    dispatch_en,
  input  logic                    dispatch_wen,
  input  logic [REG_W-1:0]        dispatch_rd,
  input  logic [TAG_W-1:0]        dispatch_tag,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*REG_W-1:0] wb_rd,
  input  logic [NUM_WB*TAG_W-1:0] wb_tag,
  input  logic [REG_W-1:0]        rs1,
  input  logic [REG_W-1:0]        rs2,
  input  logic [REG_W-1:0]        rd,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic                    rd_busy,
  output logic [TAG_W-1:0]        rs1_tag,
  output logic [TAG_W-1:0]        rs2_tag,
  output logic                    any_busy,
  output logic [REG_W:0]          busy_count
);

  localparam int CNT_W = REG_W + 1;

  logic [NUM_REGS-1:1] r_busy;
  logic [TAG_W-1:0]    r_tag [NUM_REGS-1:1];
  logic [CNT_W-1:0]    r_busy_count;

  logic                w_dispatch_set;
  logic [NUM_REGS-1:1] w_set;
  logic [NUM_REGS-1:1] w_clr;
  logic [NUM_REGS-1:0] w_busy_full;
  logic [TAG_W-1:0]    w_tag_full [NUM_REGS];
  logic                w_inc;
  logic [CNT_W-1:0]    w_dec;

  assign w_dispatch_set = dispatch_en & dispatch_wen & (dispatch_rd != '0) & ~flush;

  // Per-entry set/clear; a same-cycle dispatch to the entry masks any clear.
  always_comb begin
    // NOTE: every comb output gets a default before the loop, so no path infers a latch.
    w_set = '0;
    w_clr = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_set[i] = w_dispatch_set & (dispatch_rd == REG_W'(i));
      for (int k = 0; k < NUM_WB; k++) begin
        if (wb_valid[k] && (wb_rd[k*REG_W +: REG_W] == REG_W'(i)) && r_busy[i] &&
            (r_tag[i] == wb_tag[k*TAG_W +: TAG_W])) begin
          w_clr[i] = 1'b1;
        end
      end
      w_clr[i] = w_clr[i] & ~w_set[i];
    end
  end

  // Distinct entries cleared; several ports hitting one entry count once.
  always_comb begin
    w_dec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_dec = w_dec + CNT_W'(w_clr[i]);
    end
  end

  assign w_inc = w_dispatch_set & ~w_busy_full[dispatch_rd];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_busy       <= '0;
      r_busy_count <= '0;
      // NOTE: the tag array is reset as well, so tags read back as 0 from reset onward.
      for (int i = 1; i < NUM_REGS; i++) begin
        r_tag[i] <= '0;
      end
    end else if (flush) begin
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge state.
      r_busy       <= (r_busy & ~w_clr) | w_set;
      r_busy_count <= r_busy_count + CNT_W'(w_inc) - w_dec;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_set[i]) begin
          r_tag[i] <= dispatch_tag;
        end
      end
    end
  end

  // Lookups read registered state only; entry 0 is hardwired idle.
  assign w_busy_full = {r_busy, 1'b0};

  always_comb begin
    w_tag_full[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_tag_full[i] = r_tag[i];
    end
  end

  assign rs1_busy   = w_busy_full[rs1];
  assign rs2_busy   = w_busy_full[rs2];
  assign rd_busy    = w_busy_full[rd];
  assign rs1_tag    = rs1_busy ? w_tag_full[rs1] : '0;
  assign rs2_tag    = rs2_busy ? w_tag_full[rs2] : '0;
  assign any_busy   = (r_busy_count != '0);
  assign busy_count = r_busy_count;

endmodule

// File: tb/tb_ooo_reg_scoreboard.sv
// Directed bench for ooo_reg_scoreboard; a reference model pushes expected lookups
// to a queue, and each one is popped and compared against the DUT outputs.
module tb_ooo_reg_scoreboard;

  localparam int NUM_REGS = 32;
  localparam int REG_W    = 5;
  localparam int TAG_W    = 4;
  localparam int NUM_WB   = 2;

  logic                    CLK = 1'b0;
  logic                    RST;
  logic                    flush;
  logic                    dispatch_en;
  logic                    dispatch_wen;
  logic [REG_W-1:0]        dispatch_rd;
  logic [TAG_W-1:0]        dispatch_tag;
  logic [NUM_WB-1:0]       wb_valid;
  logic [NUM_WB*REG_W-1:0] wb_rd;
  logic [NUM_WB*TAG_W-1:0] wb_tag;
  logic [REG_W-1:0]        rs1;
  logic [REG_W-1:0]        rs2;
  logic [REG_W-1:0]        rd;
  logic                    rs1_busy;
  logic                    rs2_busy;
  logic                    rd_busy;
  logic [TAG_W-1:0]        rs1_tag;
  logic [TAG_W-1:0]        rs2_tag;
  logic                    any_busy;
  logic [REG_W:0]          busy_count;

  ooo_reg_scoreboard #(
    .NUM_REGS(NUM_REGS), .REG_W(REG_W), .TAG_W(TAG_W), .NUM_WB(NUM_WB)
  ) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .dispatch_en(dispatch_en), .dispatch_wen(dispatch_wen),
    .dispatch_rd(dispatch_rd), .dispatch_tag(dispatch_tag),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_tag(wb_tag),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
    .any_busy(any_busy), .busy_count(busy_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic             b1;
    logic             b2;
    logic             bd;
    logic [TAG_W-1:0] t1;
    logic [TAG_W-1:0] t2;
    logic             any;
    logic [31:0]      cnt;
  } exp_t;

  exp_t             sb[$];
  bit [31:0]        m_busy;
  logic [TAG_W-1:0] m_tag [NUM_REGS];
  int               vectors = 0;
  int               miscompares = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = '0;
    for (int i = 0; i < NUM_REGS; i++) m_tag[i] = '0;
  endtask

  task automatic idle_inputs();
    flush = 0; dispatch_en = 0; dispatch_wen = 0; dispatch_rd = 0; dispatch_tag = 0;
    wb_valid = 0; wb_rd = 0; wb_tag = 0;
  endtask

  task automatic drv_disp(input int r, input int t);
    dispatch_en = 1; dispatch_wen = 1;
    dispatch_rd = REG_W'(r); dispatch_tag = TAG_W'(t);
  endtask

  task automatic drv_wb(input int k, input int r, input int t);
    wb_valid[k] = 1'b1;
    wb_rd[k*REG_W +: REG_W] = REG_W'(r);
    wb_tag[k*TAG_W +: TAG_W] = TAG_W'(t);
  endtask

  // Advance one clock: the model's next state is computed from the driven inputs.
  task automatic tick();
    bit [31:0]        nb;
    logic [TAG_W-1:0] nt [NUM_REGS];
    logic [REG_W-1:0] wr;
    nb = m_busy;
    nt = m_tag;
    if (flush) begin
      nb = '0;
    end else begin
      for (int k = 0; k < NUM_WB; k++) begin
        wr = wb_rd[k*REG_W +: REG_W];
        if (wb_valid[k] && wr != 0 && m_busy[wr] && m_tag[wr] == wb_tag[k*TAG_W +: TAG_W])
          nb[wr] = 1'b0;
      end
      if (dispatch_en && dispatch_wen && dispatch_rd != 0) begin
        nb[dispatch_rd] = 1'b1;
        nt[dispatch_rd] = dispatch_tag;
      end
    end
    @(posedge CLK);
    m_busy = nb;
    m_tag  = nt;
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic look(input string name, input int a, input int b, input int d);
    exp_t e;
    rs1 = REG_W'(a); rs2 = REG_W'(b); rd = REG_W'(d);
    e.b1  = m_busy[a];
    e.b2  = m_busy[b];
    e.bd  = m_busy[d];
    e.t1  = m_busy[a] ? m_tag[a] : '0;
    e.t2  = m_busy[b] ? m_tag[b] : '0;
    e.any = |m_busy;
    e.cnt = 32'($countones(m_busy));
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk({name, ".rs1_busy"}, 32'(rs1_busy), 32'(e.b1));
    chk({name, ".rs2_busy"}, 32'(rs2_busy), 32'(e.b2));
    chk({name, ".rd_busy"},  32'(rd_busy),  32'(e.bd));
    chk({name, ".rs1_tag"},  32'(rs1_tag),  32'(e.t1));
    chk({name, ".rs2_tag"},  32'(rs2_tag),  32'(e.t2));
    chk({name, ".count"},    32'(busy_count), e.cnt);
    chk({name, ".any"},      32'(any_busy), 32'(e.any));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1; rs1 = 0; rs2 = 0; rd = 0;
    idle_inputs();
    model_reset();
    #3;
    look("in_reset", 5, 0, 31);
    @(negedge CLK);
    RST = 0;
    tick();
    look("idle", 5, 0, 31);

    // Basic dispatch then matching writeback.
    drv_disp(5, 3); tick();
    look("disp5", 5, 0, 5);
    chk("disp5.tag_const", 32'(rs1_tag), 32'd3);
    drv_wb(0, 5, 3); tick();
    look("wb5", 5, 0, 5);

    // WAW: stale writer must not clear the younger owner.
    drv_disp(7, 2); tick();
    drv_disp(7, 9); tick();
    drv_wb(0, 7, 2); tick();
    look("waw_stale", 7, 7, 7);
    chk("waw_stale.tag_const", 32'(rs1_tag), 32'd9);
    drv_wb(0, 7, 9); tick();
    look("waw_clear", 7, 0, 7);

    // Same-cycle dispatch and matching writeback: dispatch wins, count unchanged.
    drv_disp(4, 1); tick();
    drv_disp(4, 6); drv_wb(1, 4, 1); tick();
    look("collide", 4, 0, 4);
    chk("collide.count_const", 32'(busy_count), 32'd1);
    drv_wb(0, 4, 6); tick();

    // Dual writeback clearing two entries at once.
    drv_disp(10, 0); tick();
    drv_disp(11, 5); tick();
    look("dual_pre", 10, 11, 10);
    drv_wb(0, 10, 0); drv_wb(1, 11, 5); tick();
    look("dual_clr", 10, 11, 11);

    // Both ports clear the same entry: one decrement only.
    drv_disp(3, 2); tick();
    drv_disp(8, 7); tick();
    drv_wb(0, 3, 2); drv_wb(1, 3, 2); tick();
    look("same_entry", 3, 8, 3);

    // rd=0 dispatch and a non-writing dispatch change nothing.
    drv_disp(0, 4); tick();
    look("rd0", 0, 8, 0);
    drv_disp(9, 4); dispatch_wen = 0; tick();
    look("nowen", 9, 8, 9);

    // Flush with six busy entries plus a concurrent dispatch.
    drv_disp(1, 1); tick();
    drv_disp(2, 2); tick();
    drv_disp(13, 3); tick();
    drv_disp(20, 4); tick();
    drv_disp(30, 5); tick();
    look("pre_flush", 30, 8, 1);
    drv_disp(12, 6); flush = 1; tick();
    look("flush", 12, 31, 1);

    // Asynchronous reset in the middle of a clock phase.
    drv_disp(15, 11); tick();
    drv_disp(16, 12); tick();
    look("pre_rst", 15, 16, 16);
    #2;
    RST = 1;
    model_reset();
    look("async_rst", 15, 16, 16);
    @(negedge CLK);
    RST = 0;
    tick();
    look("post_rst", 15, 16, 31);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
